pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Supervises the board PLL (27 MHz ref in; outputs 100 MHz SDRAM, 100 MHz phase-shifted SDRAM pin clock, 18.367346 MHz pixel clock).
- Pulses the PLL reset, waits for a qualified lock, then releases per-domain resets in a fixed staggered order.
- On lock loss or lock timeout it re-resets the PLL, with bounded retries.
- Runs on the free-running reference clock; sits between the board reset/PLL wrapper and all downstream controllers.

Parameters:
- RST_HOLD_CYCLES, 270, PLL reset pulse width in refclk cycles (10 us).
- LOCK_TIMEOUT_CYCLES, 27000, max wait for lock after reset pulse (1 ms).
- LOCK_STABLE_CYCLES, 2700, consecutive synchronized-locked cycles required (100 us).
- STAGGER_CYCLES, 16, gap between successive domain reset releases.
- NUM_DOMAINS, 3, number of domain resets; index 0 = SDRAM ctrl, 1 = SDRAM pin clk, 2 = pixel.
- MAX_RETRIES, 7, PLL reset attempts before fault; range 1..15.

Ports:
- refclk, input, 1, 27 MHz reference clock, free-running.
- rst, input, 1, synchronous active-high reset.
- pll_locked, input, 1, PLL locked; asynchronous, double-flop synchronized internally.
- pll_rst, output, 1, PLL reset, active-high.
- domain_rst, output, NUM_DOMAINS, per-domain reset, active-high, refclk domain.
- all_ready, output, 1, high only in RUN.
- retry_count, output, 4, PLL reset attempts beyond the first, saturating.
- fault, output, 1, sticky; retries exhausted.
- state_dbg, output, 3, current state encoding.

Behaviour:
Interface rules:
- Single clock refclk; rst is synchronous and active-high.
- All outputs are registered.
- Consumers re-synchronize domain_rst into their own clock (assert async, deassert sync); this block does not.

Reset values (rst high, and the cycle after):
- pll_rst=1, domain_rst=all 1, all_ready=0, retry_count=0, fault=0, state=RESET_PLL, counters=0.
- rst mid-operation aborts any state, including FAULT, and behaves identically.

Lock qualification:
- locked_s = pll_locked after 2 flops; input-to-use latency is 2 cycles.

States:
- RESET_PLL: pll_rst=1, domain_rst all 1. After RST_HOLD_CYCLES cycles in the state, go to WAIT_LOCK with counter cleared; pll_rst drops on entry.
- WAIT_LOCK: counts cycles.
  - locked_s=1: go to STABILIZE.
  - Count reaches LOCK_TIMEOUT_CYCLES with locked_s=0: retry event.
- STABILIZE: counts consecutive locked_s=1 cycles.
  - locked_s=0: go to WAIT_LOCK. The timeout counter restarts; this is not a retry.
  - Count reaches LOCK_STABLE_CYCLES: go to RELEASE.
- RELEASE: domain_rst[0] deasserts on entry; domain_rst[k] deasserts k*STAGGER_CYCLES cycles after entry. After the last release, go to RUN the following cycle.
- RUN: all_ready=1, domain_rst all 0.
- Lock loss (locked_s=0) in RELEASE or RUN:
  - Next cycle, all domain_rst reassert and all_ready=0.
  - Counts as a retry event.
- Retry event:
  - If retry_count < MAX_RETRIES: retry_count++, go to RESET_PLL.
  - Otherwise go to FAULT.
- FAULT: fault=1, pll_rst=1, domain_rst all 1. Exited only by rst.

Boundary conditions:
- retry_count saturates at 15.
- Lock loss on the same cycle a release is due: the lock loss wins, and no domain deasserts.
- A glitch on pll_locked shorter than 1 cycle may be missed; no requirement either way.
- domain_rst never deasserts while locked_s=0.
- Release order is strictly ascending index.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum: RESET_PLL, WAIT_LOCK, STABILIZE, RELEASE, RUN, FAULT.
  - Domain index constants: DOM_SDRAM=0, DOM_SDRAM_PIN=1, DOM_PIXEL=2.
  - Default cycle constants.
- One natural sub-module: bit_sync_2ff (2-flop synchronizer for pll_locked, reused elsewhere).

Test Plan (bench params: RST_HOLD=4, TIMEOUT=50, STABLE=8, STAGGER=3, MAX_RETRIES=2):
- Clean bring-up: rst low at cycle 0; pll_locked rises at cycle 10.
  - pll_rst=1 for cycles 0-3.
  - locked_s high at cycle 12; RELEASE entered at cycle 20.
  - domain_rst becomes 3'b110, then 3'b100 at +3, then 3'b000 at +6.
  - all_ready=1 at +7; retry_count=0.
- Lock never asserts:
  - Two retries, with pll_rst re-pulsed 4 cycles each.
  - retry_count=2, then FAULT: fault=1, pll_rst=1, domain_rst=3'b111.
  - rst clears everything back to reset values.
- Lock chatter in STABILIZE: drop pll_locked for 2 cycles after 5 locked cycles.
  - Returns to WAIT_LOCK; no PLL reset; retry_count stays 0.
  - Stable count restarts; release starts 8 cycles after re-lock.
- Lock loss in RUN: deassert pll_locked.
  - 3 cycles later (2 sync + 1 register), domain_rst=3'b111 and all_ready=0.
  - State RESET_PLL; retry_count=1.
  - Re-lock yields a full ordered release.
- Lock loss mid-RELEASE: drop lock when domain_rst=3'b110.
  - Domains 1-2 never release; all reassert; retry_count increments.
- rst asserted in RUN for 1 cycle: all outputs at reset values the next cycle; sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int DOM_SDRAM     = 0;
  localparam int DOM_SDRAM_PIN = 1;
  localparam int DOM_PIXEL     = 2;

  localparam int DEF_RST_HOLD_CYCLES     = 270;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 2700;
  localparam int DEF_STAGGER_CYCLES      = 16;
  localparam int DEF_NUM_DOMAINS         = 3;
  localparam int DEF_MAX_RETRIES         = 7;

  localparam int                 RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == RETRY_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock input and sequenced reset/status outputs
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);

  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   all_ready;
  logic [RETRY_W-1:0]     retry_count;
  logic                   fault;
  state_t                 state_dbg;

  modport master (
    input  pll_locked,
    output pll_rst,
    output domain_rst,
    output all_ready,
    output retry_count,
    output fault,
    output state_dbg
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  domain_rst,
    input  all_ready,
    input  retry_count,
    input  fault,
    input  state_dbg
  );

endinterface

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module bit_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, staggered domain release, retries
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
  parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CNT_MAX  = max_int(max_int(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                    max_int(LOCK_STABLE_CYCLES, REL_LAST + 1));
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic [RETRY_W-1:0]     retry_q;
  logic                   fault_q;

  logic                   locked_s;
  logic                   retry_evt;
  logic                   retry_left;
  logic [NUM_DOMAINS-1:0] dom_entry;
  logic [NUM_DOMAINS-1:0] rel_hold;

  bit_sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  // Lock loss after release has started is treated exactly like a lock timeout.
  always_comb begin
    retry_evt = 1'b0;
    if (!locked_s) begin
      if (state == WAIT_LOCK && cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1))
        retry_evt = 1'b1;
      if (state == RELEASE || state == RUN)
        retry_evt = 1'b1;
    end
  end

  assign retry_left = (retry_q < RETRY_W'(MAX_RETRIES));

  always_comb begin
    dom_entry            = '1;
    dom_entry[DOM_SDRAM] = 1'b0;
  end

  // Domain k is released once the RELEASE counter reaches k*STAGGER_CYCLES.
  always_comb begin
    rel_hold = '1;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (int'(cnt) + 1 >= k * STAGGER_CYCLES)
        rel_hold[k] = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
      fault_q   <= 1'b0;
    end else if (retry_evt) begin
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      if (retry_left) begin
        retry_q <= retry_inc(retry_q);
        state   <= RESET_PLL;
      end else begin
        fault_q <= 1'b1;
        state   <= FAULT;
      end
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // The cycle that sees lock counts as the first stable cycle.
          if (locked_s) begin
            state <= STABILIZE;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt >= CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state <= RELEASE;
            cnt   <= '0;
            dom_q <= dom_entry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == CNT_W'(REL_LAST)) begin
            state   <= RUN;
            ready_q <= 1'b1;
            dom_q   <= '0;
          end else begin
            cnt   <= cnt + 1'b1;
            dom_q <= rel_hold;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
          dom_q   <= '0;
        end
        FAULT: begin
          pll_rst_q <= 1'b1;
          dom_q     <= '1;
          ready_q   <= 1'b0;
          fault_q   <= 1'b1;
        end
        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
          dom_q     <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.domain_rst  = dom_q;
  assign bus.all_ready   = ready_q;
  assign bus.retry_count = retry_q;
  assign bus.fault       = fault_q;
  assign bus.state_dbg   = state;

endmodule
